// File: rtl/sel5_rr_arbiter.sv
// sel5_rr_arbiter: four-requester round-robin arbiter that owns the selects of
// a 5-input AND decode (I0/I1 active-low, I2..I4 active-high).
// A grant lasts until DONE, until the owner drops REQ, or until MAX_TENURE
// cycles have passed. Every handover goes through a dead GAP cycle, so two
// owners never see the decode output high back to back.
// Optional feature: define SEL5_ARB_LOCK_EN to add a LOCK input that holds
// off tenure expiry while it is high.
module sel5_rr_arbiter #(
  parameter int N_REQ      = 4,
  parameter int MAX_TENURE = 8,
  parameter int TW         = 4
) (
  input  logic             C,
  input  logic             R_N,
  input  logic             EN,
  input  logic [N_REQ-1:0] REQ,
  input  logic             DONE,
`ifdef SEL5_ARB_LOCK_EN
  input  logic             LOCK,
`endif
  output logic [N_REQ-1:0] GNT,
  output logic             BUSY,
  output logic             EXPIRE,
  output logic [4:0]       SEL
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [1:0]      ptr;        // requester that has top priority next arbitration
  logic [1:0]      owner;      // current/last owner, drives SEL[1:0]
  logic [1:0]      winner;
  logic [TW-1:0]   tenure;
  logic            en_q;
  logic            lock;
  logic            req_any;
  logic            release_c;
  logic            expire_c;

`ifdef SEL5_ARB_LOCK_EN
  assign lock = LOCK;
`else
  assign lock = 1'b0;
`endif

  assign req_any = |REQ;

  // Round-robin pick: first set request at ptr, ptr+1, ... with 2-bit wrap.
  // Scanning from the far end lets the nearest offset overwrite the others.
  always_comb begin
    winner = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (REQ[ptr + 2'(k)]) winner = ptr + 2'(k);
    end
  end

  // Release beats expiry when both happen in the same cycle.
  always_comb begin
    release_c = (state == GRANT) && (DONE || !REQ[owner]);
    expire_c  = (state == GRANT) && !release_c && !lock &&
                (tenure == TW'(MAX_TENURE));
  end

  // State register.
  always_ff @(posedge C) begin
    if (!R_N) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_any) state_nxt = GRANT;
      GRANT:   if (release_c || expire_c) state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered grant, busy, expiry pulse, tenure count and pointer.
  always_ff @(posedge C) begin
    if (!R_N) begin
      GNT    <= '0;
      BUSY   <= 1'b0;
      EXPIRE <= 1'b0;
      owner  <= 2'd0;
      ptr    <= 2'd0;
      tenure <= '0;
      en_q   <= 1'b0;
    end else begin
      en_q   <= EN;
      EXPIRE <= 1'b0;
      case (state)
        IDLE: begin
          if (req_any) begin
            GNT         <= '0;
            GNT[winner] <= 1'b1;
            BUSY        <= 1'b1;
            owner       <= winner;
            tenure      <= TW'(1);
          end
        end
        GRANT: begin
          if (release_c || expire_c) begin
            GNT    <= '0;
            BUSY   <= 1'b0;
            EXPIRE <= expire_c;
            ptr    <= owner + 2'd1;
            tenure <= '0;
          end else if (tenure != TW'(MAX_TENURE)) begin
            tenure <= tenure + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Decode selects; owner index is held while idle so SEL[1:0] stays stable.
  always_comb begin
    SEL = {en_q, ~EXPIRE, BUSY, owner};
  end

  // Grant is never multi-hot and is present exactly when BUSY is.
  a_gnt_onehot: assert property (@(posedge C) disable iff (!R_N) $onehot0(GNT));
  a_gnt_busy:   assert property (@(posedge C) disable iff (!R_N) (GNT != '0) == BUSY);

endmodule

// File: tb/tb_sel5_rr_arbiter.sv
// Bench for sel5_rr_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the arbitration rules.
module tb_sel5_rr_arbiter;
  localparam int MAXT = 8;

  logic       C = 1'b0;
  logic       R_N, EN, DONE, LOCK;
  logic [3:0] REQ;
  logic [3:0] GNT;
  logic       BUSY, EXPIRE;
  logic [4:0] SEL;

  always #5 C = ~C;

  sel5_rr_arbiter #(.N_REQ(4), .MAX_TENURE(MAXT), .TW(4)) dut (
    .C(C), .R_N(R_N), .EN(EN), .REQ(REQ), .DONE(DONE),
`ifdef SEL5_ARB_LOCK_EN
    .LOCK(LOCK),
`endif
    .GNT(GNT), .BUSY(BUSY), .EXPIRE(EXPIRE), .SEL(SEL)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Behavioural model: owner = -1 when nobody holds the resource,
  // phase 0 = arbitrating, 1 = granted, 2 = dead cycle after a grant.
  int m_phase, m_owner, m_held, m_ptr, m_idx;
  bit m_exp, m_enq;

  task automatic model_edge();
    bit rel;
    if (!R_N) begin
      m_phase = 0; m_owner = -1; m_held = 0; m_ptr = 0; m_idx = 0;
      m_exp = 0; m_enq = 0;
      return;
    end
    m_enq = EN;
    m_exp = 0;
    case (m_phase)
      0: if (REQ != 0) begin
           for (int k = 3; k >= 0; k--)
             if (REQ[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
           m_idx = m_owner; m_held = 1; m_phase = 1;
         end
      1: begin
           rel = DONE || !REQ[m_owner];
`ifdef SEL5_ARB_LOCK_EN
           if (rel || (m_held >= MAXT && !LOCK)) begin
`else
           if (rel || m_held >= MAXT) begin
`endif
             m_exp = !rel;
             m_ptr = (m_owner + 1) % 4;
             m_owner = -1; m_phase = 2;
           end else begin
             m_held = (m_held + 1 > MAXT) ? MAXT : m_held + 1;
           end
         end
      default: m_phase = 0;
    endcase
  endtask

  task automatic step(input logic rn, input logic en, input logic [3:0] req,
                      input logic done, input logic lk);
    logic [3:0] eg;
    @(negedge C);
    R_N = rn; EN = en; REQ = req; DONE = done; LOCK = lk;
    @(posedge C);
    model_edge();
    #1;
    eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
    chk("gnt", GNT, eg);
    chk("busy", BUSY, m_owner >= 0);
    chk("expire", EXPIRE, m_exp);
    chk("sel", SEL, {m_enq, ~m_exp, m_owner >= 0, 2'(m_idx)});
  endtask

  task automatic do_reset();
    step(0, 1, 4'b0000, 0, 0);
  endtask

  initial begin
    int cnt, hold, ng, bound;
    int order[5];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    logic [3:0] prev, rq;
    R_N = 0; EN = 0; REQ = 0; DONE = 0; LOCK = 0;

    // Reset with all requests pending, then the first grant goes to 0.
    step(0, 1, 4'b1111, 0, 0);
    step(0, 1, 4'b1111, 0, 0);
    chk("rst_gnt", GNT, 4'd0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_sel", SEL, 5'b01000);
    step(1, 1, 4'b1111, 0, 0);
    chk("first_gnt", GNT, 4'b0001);

    // Rotation: owners drop after two cycles; order must be 0,1,2,3,0.
    do_reset();
    hold = 0; ng = 0; prev = 0;
    for (int i = 0; i < 60 && ng < 5; i++) begin
      hold = (GNT != 0) ? hold + 1 : 0;
      step(1, 1, 4'b1111, hold >= 2, 0);
      if (GNT != 0 && prev == 0) begin
        order[ng] = (GNT == 4'b0001) ? 0 : (GNT == 4'b0010) ? 1 : (GNT == 4'b0100) ? 2 : 3;
        ng++;
      end
      prev = GNT;
    end
    chk("rot_count", ng, 5);
    for (int i = 0; i < 5; i++) chk($sformatf("rot_order%0d", i), order[i], exp_order[i]);

    // Expiry: single requester held for the full tenure, then re-granted.
    do_reset();
    step(1, 1, 4'b0010, 0, 0);
    cnt = 0; bound = 0;
    while (GNT == 4'b0010 && bound < 20) begin
      cnt++; bound++;
      step(1, 1, 4'b0010, 0, 0);
    end
    chk("exp_len", cnt, MAXT);
    chk("exp_pulse", EXPIRE, 1'b1);
    chk("exp_sel3", SEL[3], 1'b0);
    step(1, 1, 4'b0010, 0, 0);
    chk("exp_gap_gnt", GNT, 4'd0);
    chk("exp_gap_pulse", EXPIRE, 1'b0);
    step(1, 1, 4'b0010, 0, 0);
    chk("exp_regrant", GNT, 4'b0010);

    // Fairness: requester 0 expires, requester 1 is served before it again.
    do_reset();
    bound = 0;
    do begin
      step(1, 1, 4'b0011, 0, 0);
      bound++;
    end while (!EXPIRE && bound < 20);
    chk("fair_expired", EXPIRE, 1'b1);
    step(1, 1, 4'b0011, 0, 0);
    step(1, 1, 4'b0011, 0, 0);
    chk("fair_next", GNT, 4'b0010);

    // DONE exactly when tenure hits the limit: plain release, no pulse.
    do_reset();
    step(1, 1, 4'b0001, 0, 0);
    for (int i = 0; i < MAXT - 1; i++) step(1, 1, 4'b0001, 0, 0);
    chk("sim_still", GNT, 4'b0001);
    step(1, 1, 4'b0001, 1, 0);
    chk("sim_gnt", GNT, 4'd0);
    chk("sim_noexp", EXPIRE, 1'b0);

    // Reset while requester 2 owns the resource.
    do_reset();
    step(1, 1, 4'b0100, 0, 0);
    step(1, 1, 4'b0100, 0, 0);
    chk("mid_pre", GNT, 4'b0100);
    step(0, 1, 4'b0100, 0, 0);
    chk("mid_gnt", GNT, 4'd0);
    chk("mid_noexp", EXPIRE, 1'b0);

`ifdef SEL5_ARB_LOCK_EN
    // Locked grant outlives the tenure limit without expiring.
    do_reset();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 4'b0001, 0, 1);
      if (EXPIRE) cnt++;
    end
    chk("lock_noexp", cnt, 0);
    chk("lock_gnt", GNT, 4'b0001);
`endif

    // Random traffic against the model; requests mostly persist.
    do_reset();
    rq = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), rq,
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
